fifo_drain_ctrl: RTL and testbench

//  Downstream consumer of the FIFO: pops words whenever FIFO_empty is low
//  and forwards them to the next stage over a valid/ready stream.

---
 rtl/fifo_drain_if.sv | 29 ++
 rtl/fifo_drain_ctrl.sv | 148 ++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_if
// Brief    : FIFO read port plus outgoing valid/ready stream of the drain
//            controller. The master modport is the controller side.
// Revision : 1.0
// ============================================================================
interface fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] FIFO_data_out;
  logic                  FIFO_empty;
  logic                  FIFO_full;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_in;

  modport master (
    input  FIFO_data_out, FIFO_empty, FIFO_full, ready_in,
    output read_enable, data_out, valid_out
  );

  modport slave (
    output FIFO_data_out, FIFO_empty, FIFO_full, ready_in,
    input  read_enable, data_out, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain_ctrl
// Brief    : Pops a FIFO with 1-clk read latency into a 2-entry skid buffer and
//            streams the words out over valid/ready. Define CHECKSUM_EN to add
//            an XOR checksum output of all delivered words.
// Revision : 1.0
// ============================================================================
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  fifo_drain_if.master          bus,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  stat_full,
  output logic                  busy
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_occ;
  logic                  r_rd_en;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_stat_full;
  logic                  w_xfer;
  logic                  w_cap;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_start;
  logic [1:0]            w_occ_freed;

  assign w_xfer      = (r_occ != 2'd0) && bus.ready_in;
  assign w_cap       = r_rd_en;
  // A word leaving this edge frees its slot; the in-flight word needs one.
  assign w_occ_freed = r_occ - {1'b0, w_xfer};
  assign w_credit    = ({1'b0, w_occ_freed} + {2'b00, r_rd_en}) <= 3'd1;
  assign w_start     = (r_state == S_IDLE) && Enable;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_pop = Enable && !bus.FIFO_empty && w_credit;
        if (!Enable) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (Enable) begin
          w_state_nxt = S_RUN;
        end else if (!r_rd_en && (r_occ == 2'd0)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= 2'd0;
      r_rd_en     <= 1'b0;
      r_count     <= '0;
      r_stat_full <= 1'b0;
    end else begin
      r_rd_en     <= w_pop;
      r_stat_full <= bus.FIFO_full;
      if (w_xfer) r_count <= r_count + c_cnt_one;

      if (w_xfer && w_cap) begin
        if (r_occ == 2'd2) begin
          r_head <= r_tail;
          r_tail <= bus.FIFO_data_out;
        end else begin
          r_head <= bus.FIFO_data_out;
        end
      end else if (w_xfer) begin
        if (r_occ == 2'd2) r_head <= r_tail;
        r_occ <= r_occ - 2'd1;
      end else if (w_cap) begin
        if (r_occ == 2'd0) begin
          r_head <= bus.FIFO_data_out;
        end else begin
          r_tail <= bus.FIFO_data_out;
        end
        r_occ <= r_occ + 2'd1;
      end
    end
  end

`ifdef CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // IDLE holds an empty buffer, so the clear never competes with a transfer.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum ^ r_head;
    end
  end

  assign checksum = r_checksum;
`endif

  a_no_capture_into_full: assert property (@(posedge clk) disable iff (Reset)
    !(w_cap && !w_xfer && (r_occ == 2'd2)));

  assign bus.read_enable = r_rd_en;
  assign bus.data_out    = r_head;
  assign bus.valid_out   = (r_occ != 2'd0);
  assign word_count      = r_count;
  assign stat_full       = r_stat_full;
  assign busy            = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_drain_ctrl
// Brief    : Self-checking bench for fifo_drain_ctrl: queue-based stream model
//            compared every cycle, plus directed literal scenarios.
// Revision : 1.0
// ============================================================================
module tb_fifo_drain_ctrl;
  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int DEPTH   = 8192;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic enable     = 1'b0;
  logic ready      = 1'b0;
  logic full       = 1'b0;
  logic fifo_flush = 1'b0;
  logic cmp_en     = 1'b0;
  logic [CW-1:0] word_count;
  logic          stat_full;
  logic          busy;
`ifdef CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem [DEPTH];
  int wr_idx = 0;
  int rd_idx = 0;
  int cyc    = 0;
  logic [DW-1:0] got [$];
  int            got_cyc [$];

  fifo_drain_if #(.DATA_WIDTH(DW)) bus ();

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .Reset      (rst),
    .Enable     (enable),
    .bus        (bus),
    .word_count (word_count),
    .stat_full  (stat_full),
    .busy       (busy)
`ifdef CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO with a 1-clk read latency; FIFO_empty counts only unclaimed words.
  assign bus.FIFO_data_out = mem[rd_idx % DEPTH];
  assign bus.FIFO_empty    = (wr_idx - rd_idx - ((bus.read_enable === 1'b1) ? 1 : 0)) <= 0;
  assign bus.FIFO_full     = full;
  assign bus.ready_in      = ready;

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_idx <= wr_idx;
    end else if (bus.read_enable === 1'b1) begin
      chk("pop_on_empty", (rd_idx < wr_idx) ? 32'd1 : 32'd0, 32'd1);
      if (rd_idx < wr_idx) rd_idx <= rd_idx + 1;
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b0 && bus.valid_out === 1'b1 && ready === 1'b1) begin
      got.push_back(bus.data_out);
      got_cyc.push_back(cyc);
    end
    cyc++;
  end

  // Reference model: stream semantics with a queue as the buffer.
  logic [DW-1:0] m_buf [$];
  bit            m_inflight;
  int            m_mode;
  int            m_count;
  logic [DW-1:0] m_cks;
  logic          m_full;
  bit            m_xfer;
  bit            m_pop;
  int            m_nxt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_buf.delete();
      m_inflight = 1'b0;
      m_mode     = M_IDLE;
      m_count    = 0;
      m_cks      = '0;
      m_full     = 1'b0;
    end else begin
      m_xfer = (m_buf.size() > 0) && (ready === 1'b1);
      m_pop  = (m_mode == M_RUN) && (enable === 1'b1) && (bus.FIFO_empty === 1'b0) &&
               (m_buf.size() - int'(m_xfer) + int'(m_inflight) + 1 <= 2);
      m_nxt  = m_mode;
      if (m_mode == M_IDLE && enable) m_nxt = M_RUN;
      else if (m_mode == M_RUN && !enable) m_nxt = M_DRAIN;
      else if (m_mode == M_DRAIN && enable) m_nxt = M_RUN;
      else if (m_mode == M_DRAIN && !m_inflight && m_buf.size() == 0) m_nxt = M_IDLE;
      if (m_mode == M_IDLE && enable) m_cks = '0;
      if (m_xfer) begin
        m_cks   = m_cks ^ m_buf[0];
        m_count = (m_count + 1) % (1 << CW);
        void'(m_buf.pop_front());
      end
      if (m_inflight) begin
        if (m_buf.size() >= 2) chk("model_capture_into_full", 32'd1, 32'd0);
        m_buf.push_back(bus.FIFO_data_out);
      end
      m_inflight = m_pop;
      m_full     = full;
      m_mode     = m_nxt;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("valid_out", bus.valid_out, (m_buf.size() > 0) ? 32'd1 : 32'd0);
      if (m_buf.size() > 0) chk("data_out", bus.data_out, m_buf[0]);
      chk("read_enable", bus.read_enable, m_inflight);
      chk("word_count", word_count, m_count);
      chk("stat_full", stat_full, m_full);
      chk("busy", busy, (m_mode != M_IDLE) ? 32'd1 : 32'd0);
`ifdef CHECKSUM_EN
      chk("checksum", checksum, m_cks);
`endif
    end
  end

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic push(input logic [DW-1:0] d);
    mem[wr_idx % DEPTH] = d;
    wr_idx++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; ready = 1'b0; fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    got_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] lit [5];
    int k;
    int pops;
    int vals;
    lit = '{8'hFF, 8'hAF, 8'h17, 8'hB8, 8'h6A};
    tick(2);
    cmp_en = 1'b1;

    // T2: plain stream, back to back
    do_reset();
    for (int i = 0; i < 5; i++) push(lit[i]);
    enable = 1'b1; ready = 1'b1;
    tick(15);
    chk("t2_words", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_order", got_at(i), lit[i]);
    chk("t2_back_to_back", (got_cyc.size() == 5) ? got_cyc[4] - got_cyc[0] : -1, 4);
    chk("t2_word_count", word_count, 5);
`ifdef CHECKSUM_EN
    chk("t2_checksum", checksum, 8'h95);
`endif

    // T3: back-pressure right after the first word
    do_reset();
    for (int i = 0; i < 5; i++) push(lit[i]);
    enable = 1'b1; ready = 1'b1;
    for (k = 0; k < 20 && got.size() < 1; k++) @(negedge clk);
    chk("t3_first_word", got.size(), 1);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", bus.valid_out, 1);
      chk("t3_hold_data", bus.data_out, 8'hAF);
      chk("t3_pop_stalled", bus.read_enable, 0);
    end
    ready = 1'b1;
    tick(15);
    chk("t3_words", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("t3_order", got_at(i), lit[i]);
    chk("t3_word_count", word_count, 5);

    // T4: FIFO empty throughout
    do_reset();
    enable = 1'b1; ready = 1'b1;
    pops = 0; vals = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pops += int'(bus.read_enable);
      vals += int'(bus.valid_out);
    end
    chk("t4_no_pops", pops, 0);
    chk("t4_no_valid", vals, 0);
    chk("t4_busy_run", busy, 1);

    // T5: drop Enable one clk after the first pop
    do_reset();
    push(8'hFF); push(8'h11); push(8'h22);
    enable = 1'b1; ready = 1'b1;
    for (k = 0; k < 10 && bus.read_enable !== 1'b1; k++) @(negedge clk);
    chk("t5_first_pop", bus.read_enable, 1);
    enable = 1'b0;
    pops = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pops += int'(bus.read_enable);
    end
    chk("t5_single_pop", pops, 1);
    chk("t5_words", got.size(), 1);
    chk("t5_word", got_at(0), 8'hFF);
    chk("t5_idle", busy, 0);
`ifdef CHECKSUM_EN
    chk("t5_checksum", checksum, 8'hFF);
`endif

    // T6: word_count wraps with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) push(8'(i * 3 + 1));
    enable = 1'b1; ready = 1'b1;
    tick(30);
    chk("t6_words", got.size(), 17);
    chk("t6_word_count_wrap", word_count, 1);

    // T1: asynchronous reset in mid-stream
    do_reset();
    for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
    enable = 1'b1; ready = 1'b1; full = 1'b1;
    tick(5);
    chk("t1_streaming", busy, 1);
    rst = 1'b1;
    #1;
    chk("t1_read_enable", bus.read_enable, 0);
    chk("t1_valid_out", bus.valid_out, 0);
    chk("t1_data_out", bus.data_out, 0);
    chk("t1_word_count", word_count, 0);
    chk("t1_stat_full", stat_full, 0);
    chk("t1_busy", busy, 0);
    full = 1'b0;

    // Random traffic against the model
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) < 4) push(8'($urandom));
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      full = ($urandom_range(0, 7) == 0);
      if (i == 1500) rst = 1'b1;
      if (i == 1502) rst = 1'b0;
    end
    enable = 1'b1; ready = 1'b1;
    for (k = 0; k < 3000 && (wr_idx != rd_idx || bus.valid_out !== 1'b0); k++) @(negedge clk);
    chk("rand_fifo_drained", wr_idx - rd_idx, 0);
    chk("rand_buffer_empty", bus.valid_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
